// File: rtl/pim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pim_pkg
// Brief    : Shared state encoding and default sizing for the PIM matrix engine.
// Revision : 1.0
// ============================================================================
package pim_pkg;

    localparam int PIM_WIDTH           = 32;
    localparam int PIM_MAX_MATRIX_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } pim_state_t;

endpackage
`default_nettype wire

// File: rtl/pim_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : pim_mac_lane
// Brief    : One multiply-accumulate lane; o_sum is the running sum including
//            the current product. Signed mode selected by PIM_SIGNED_MAC_EN.
// Revision : 1.0
// ============================================================================
module pim_mac_lane
    import pim_pkg::*;
#(
    parameter int WIDTH = PIM_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_last,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum
);

    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_prod;

`ifdef PIM_SIGNED_MAC_EN
    logic signed [WIDTH-1:0] w_sprod;
    assign w_sprod = $signed(i_a) * $signed(i_b);
    assign w_prod  = w_sprod;
`else
    assign w_prod  = i_a * i_b;
`endif

    assign o_sum = r_acc + w_prod;

    // On the last k the sum leaves through o_sum and the lane restarts at zero.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_last ? '0 : o_sum;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pim_controller.sv
`default_nettype none
// ============================================================================
// Module   : pim_controller
// Brief    : Batched C = A x B engine with NUM_PIMS MAC lanes; result_ready
//            pulses once per run. Optional macro: PIM_SIGNED_MAC_EN.
// Revision : 1.0
// ============================================================================
module pim_controller
    import pim_pkg::*;
#(
    parameter int WIDTH           = PIM_WIDTH,
    parameter int MAX_MATRIX_SIZE = PIM_MAX_MATRIX_SIZE,
    parameter int MATRIX_SIZE     = 8,
    parameter int NUM_PIMS        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] matrix_A [MATRIX_SIZE*MATRIX_SIZE],
    input  logic [WIDTH-1:0] matrix_B [MATRIX_SIZE*MATRIX_SIZE],
    output logic [WIDTH-1:0] result   [MATRIX_SIZE*MATRIX_SIZE],
    output logic             result_ready
);

    localparam int c_NN = MATRIX_SIZE * MATRIX_SIZE;
    localparam int c_NB = (c_NN + NUM_PIMS - 1) / NUM_PIMS;
    localparam int c_IW = (c_NN > 1) ? $clog2(c_NN) : 1;
    localparam int c_KW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
    localparam int c_BW = (c_NB > 1) ? $clog2(c_NB) : 1;
    localparam int c_EW = $clog2(c_NB * NUM_PIMS + 1);

    if (MATRIX_SIZE > MAX_MATRIX_SIZE || NUM_PIMS < 1 || NUM_PIMS > c_NN) begin : g_param_err
        $error("pim_controller: illegal MATRIX_SIZE/NUM_PIMS combination");
    end

    pim_state_t       r_state;
    pim_state_t       w_next;
    logic [WIDTH-1:0] r_a      [c_NN];
    logic [WIDTH-1:0] r_b      [c_NN];
    logic [WIDTH-1:0] r_result [c_NN];
    logic [c_KW-1:0]  r_k;
    logic [c_BW-1:0]  r_batch;
    logic             w_last_k;
    logic             w_last_batch;
    logic             w_clear;
    logic [WIDTH-1:0] w_sum [NUM_PIMS];
    logic [c_IW-1:0]  w_idx [NUM_PIMS];
    logic             w_act [NUM_PIMS];

    assign w_last_k     = (r_k == c_KW'(MATRIX_SIZE - 1));
    assign w_last_batch = (r_batch == c_BW'(c_NB - 1));
    assign w_clear      = (r_state == IDLE);
    assign result_ready = (r_state == DONE);
    assign result       = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = COMPUTE;
            COMPUTE: if (w_last_k && w_last_batch) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    for (genvar p = 0; p < NUM_PIMS; p++) begin : g_lane
        logic [c_EW-1:0]  w_e;
        logic [c_EW-1:0]  w_row;
        logic [c_EW-1:0]  w_col;
        logic [c_EW-1:0]  w_ai;
        logic [c_EW-1:0]  w_bi;
        logic [WIDTH-1:0] w_opa;
        logic [WIDTH-1:0] w_opb;

        // Lane p owns element batch*NUM_PIMS + p; tail lanes of the last batch sit idle.
        assign w_e      = c_EW'(r_batch) * c_EW'(NUM_PIMS) + c_EW'(p);
        assign w_row    = w_e / c_EW'(MATRIX_SIZE);
        assign w_col    = w_e % c_EW'(MATRIX_SIZE);
        assign w_ai     = w_row * c_EW'(MATRIX_SIZE) + c_EW'(r_k);
        assign w_bi     = c_EW'(r_k) * c_EW'(MATRIX_SIZE) + w_col;
        assign w_act[p] = (r_state == COMPUTE) && (w_e < c_EW'(c_NN));
        assign w_idx[p] = w_act[p] ? c_IW'(w_e) : '0;
        assign w_opa    = w_act[p] ? r_a[c_IW'(w_ai)] : '0;
        assign w_opb    = w_act[p] ? r_b[c_IW'(w_bi)] : '0;

        pim_mac_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_clear (w_clear),
            .i_en    (w_act[p]),
            .i_last  (w_last_k),
            .i_a     (w_opa),
            .i_b     (w_opb),
            .o_sum   (w_sum[p])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_k     <= '0;
            r_batch <= '0;
            for (int i = 0; i < c_NN; i++) begin
                r_a[i]      <= '0;
                r_b[i]      <= '0;
                r_result[i] <= '0;
            end
        end else if (r_state == IDLE && start) begin
            r_a     <= matrix_A;
            r_b     <= matrix_B;
            r_k     <= '0;
            r_batch <= '0;
        end else if (r_state == COMPUTE) begin
            if (w_last_k) begin
                r_k     <= '0;
                r_batch <= w_last_batch ? '0 : r_batch + c_BW'(1);
            end else begin
                r_k <= r_k + c_KW'(1);
            end
            for (int p = 0; p < NUM_PIMS; p++) begin
                if (w_act[p] && w_last_k) begin
                    r_result[w_idx[p]] <= w_sum[p];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pim_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pim_controller
// Brief    : Randomized self-checking bench for pim_controller (8x8/8 lanes and
//            4x4/3 lanes) against a plain triple-loop matrix product.
// Revision : 1.0
// ============================================================================
module tb_pim_controller;

    localparam int N   = 8;
    localparam int NN  = 64;
    localparam int NS  = 4;
    localparam int NNS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_b, start_s, rdy_b, rdy_s;
    logic [31:0] a_b [NN];
    logic [31:0] b_b [NN];
    logic [31:0] res_b [NN];
    logic [31:0] exp_b [NN];
    logic [31:0] a_s [NNS];
    logic [31:0] b_s [NNS];
    logic [31:0] res_s [NNS];
    logic [31:0] exp_s [NNS];
    int n_chk = 0;
    int n_fail = 0;

    pim_controller #(.MATRIX_SIZE(N), .NUM_PIMS(8)) dut (
        .clk(clk), .rst(rst), .start(start_b), .matrix_A(a_b), .matrix_B(b_b),
        .result(res_b), .result_ready(rdy_b)
    );

    pim_controller #(.MATRIX_SIZE(NS), .NUM_PIMS(3)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .matrix_A(a_s), .matrix_B(b_s),
        .result(res_s), .result_ready(rdy_s)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // C[i][j] = sum_k A[i][k]*B[k][j], modulo 2^32
    function automatic void matmul(input int n, input logic [31:0] a [NN],
                                   input logic [31:0] b [NN], output logic [31:0] c [NN]);
        for (int i = 0; i < NN; i++) c[i] = '0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                for (int k = 0; k < n; k++)
                    c[i*n+j] = c[i*n+j] + a[i*n+k] * b[k*n+j];
    endfunction

    task automatic model_b();
        matmul(N, a_b, b_b, exp_b);
    endtask

    task automatic model_s();
        logic [31:0] ta [NN];
        logic [31:0] tb [NN];
        logic [31:0] tc [NN];
        for (int i = 0; i < NN; i++) begin
            ta[i] = (i < NNS) ? a_s[i] : 32'd0;
            tb[i] = (i < NNS) ? b_s[i] : 32'd0;
        end
        matmul(NS, ta, tb, tc);
        for (int i = 0; i < NNS; i++) exp_s[i] = tc[i];
    endtask

    task automatic rand_b(input logic [31:0] mask);
        for (int i = 0; i < NN; i++) begin
            a_b[i] = $urandom() & mask;
            b_b[i] = $urandom() & mask;
        end
    endtask

    task automatic check_res_b(input string tag);
        for (int i = 0; i < NN; i++) check($sformatf("%s[%0d]", tag, i), res_b[i], exp_b[i]);
    endtask

    // Launches one run; lat counts edges with the start edge as 1.
    task automatic go_b(output int lat);
        model_b();
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        lat = 1;
        while (!rdy_b && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_b(input string tag);
        int lat;
        go_b(lat);
        check({tag, "_lat"}, lat, 65);
        check_res_b(tag);
        @(posedge clk); #1;
        check({tag, "_pulse_w"}, rdy_b, 1'b0);
    endtask

    initial begin
        int lat, cyc, pulses, first, second;
        rst = 1'b1; start_b = 1'b0; start_s = 1'b0;
        for (int i = 0; i < NN; i++) begin a_b[i] = '0; b_b[i] = '0; end
        for (int i = 0; i < NNS; i++) begin a_s[i] = '0; b_s[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdy_b", rdy_b, 1'b0);
        check("rst_rdy_s", rdy_s, 1'b0);
        for (int i = 0; i < NN; i++) check($sformatf("rst_res[%0d]", i), res_b[i], 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity times ramp
        for (int i = 0; i < NN; i++) begin
            a_b[i] = (i / N == i % N) ? 32'd1 : 32'd0;
            b_b[i] = i;
        end
        run_b("ident");
        check("ident_63", res_b[63], 32'd63);

        // Constant matrices, then hold check while inputs churn
        for (int i = 0; i < NN; i++) begin a_b[i] = 32'd2; b_b[i] = 32'd3; end
        run_b("const");
        check("const_0", res_b[0], 32'd48);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            rand_b(32'hFFFF_FFFF);
            @(posedge clk); #1;
            if (rdy_b) pulses++;
        end
        check("hold_pulses", pulses, 0);
        for (int i = 0; i < NN; i++) check($sformatf("hold[%0d]", i), res_b[i], 32'd48);

        // Wraparound
        for (int i = 0; i < NN; i++) begin a_b[i] = '0; b_b[i] = '0; end
        a_b[0] = 32'hFFFF_FFFF; b_b[0] = 32'd2;
        run_b("wrap");
        check("wrap_0", res_b[0], 32'hFFFF_FFFE);

        // Second start mid-run is ignored
        rand_b(32'hFFFF_FFFF);
        model_b();
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        cyc = 1; pulses = 0; first = 0;
        repeat (100) begin
            if (cyc == 10) begin
                rand_b(32'hFFFF_FFFF);
                start_b = 1'b1;
            end else begin
                start_b = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (rdy_b) begin
                pulses++;
                if (first == 0) first = cyc;
            end
        end
        start_b = 1'b0;
        check("ign_pulses", pulses, 1);
        check("ign_lat", first, 65);
        check_res_b("ign");

        // Reset in the middle of COMPUTE
        rand_b(32'hFFFF_FFFF);
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < NN; i++) check($sformatf("abort[%0d]", i), res_b[i], 32'd0);
        pulses = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (rdy_b) pulses++;
        end
        check("abort_pulses", pulses, 0);
        rand_b(32'hFFFF_FFFF);
        run_b("after_rst");

        // start held high: back-to-back runs
        rand_b(32'hFFFF_FFFF);
        model_b();
        start_b = 1'b1;
        @(posedge clk); #1;
        cyc = 1; pulses = 0; first = 0; second = 0;
        while (cyc < 140) begin
            @(posedge clk); #1;
            cyc++;
            if (rdy_b) begin
                pulses++;
                if (first == 0) first = cyc;
                else if (second == 0) second = cyc;
            end
        end
        start_b = 1'b0;
        check("b2b_pulses", pulses, 2);
        check("b2b_first", first, 65);
        check("b2b_second", second, 131);
        cyc = 0;
        while (!rdy_b && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_tail_done", rdy_b, 1'b1);
        check_res_b("b2b");
        @(posedge clk); #1;

        // Random full-width runs
        for (int r = 0; r < 2; r++) begin
            rand_b(32'hFFFF_FFFF);
            run_b($sformatf("rnd%0d", r));
        end

        // 4x4 with three lanes, 8-bit operands
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NNS; i++) begin
                a_s[i] = $urandom_range(255);
                b_s[i] = $urandom_range(255);
            end
            model_s();
            start_s = 1'b1;
            @(posedge clk); #1;
            start_s = 1'b0;
            lat = 1;
            while (!rdy_s && lat < 100) begin
                @(posedge clk); #1;
                lat++;
            end
            check($sformatf("s%0d_lat", r), lat, 25);
            for (int i = 0; i < NNS; i++)
                check($sformatf("s%0d[%0d]", r, i), res_s[i], exp_s[i]);
            @(posedge clk); #1;
            check($sformatf("s%0d_pulse_w", r), rdy_s, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
